// File: rtl/nukv_row_packer.sv
// Packs rotated row vectors into memory words, each value optionally preceded by a size header word.
// Build option: define NUKV_PACKER_HDR_EN to emit the per-value header word.
module nukv_row_packer #(
    parameter int MEMORY_WIDTH        = 512,
    parameter int COL_COUNT           = 3,
    parameter int COL_WIDTH           = 64,
    parameter int VALUE_SIZE_BYTES_NO = 2,
    localparam int HDR_W  = 8 * VALUE_SIZE_BYTES_NO,
    localparam int ROW_W  = COL_COUNT * COL_WIDTH,
    localparam int RPW    = MEMORY_WIDTH / ROW_W,
    localparam int SLOT_W = (RPW > 1) ? $clog2(RPW) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HDR_W-1:0]        value_size_data,
    input  logic [ROW_W-1:0]        input_data,
    input  logic                    input_valid,
    input  logic                    input_last,
    output logic                    input_ready,
    output logic [MEMORY_WIDTH-1:0] output_data,
    output logic                    output_valid,
    output logic                    output_last,
    input  logic                    output_ready
);

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_PACK = 1'b1;
`ifdef NUKV_PACKER_HDR_EN
    localparam logic [0:0] S_START = S_HDR;
`else
    localparam logic [0:0] S_START = S_PACK;
    logic unused_size;
    assign unused_size = ^value_size_data;
`endif

    logic [0:0]                  state;
    logic [SLOT_W-1:0]           slot;
    logic [RPW-1:0][ROW_W-1:0]   acc;
    logic [RPW-1:0][ROW_W-1:0]   merged;
    logic                        reg_free;
    logic                        completing;
    logic                        accept;

    assign reg_free   = !output_valid || output_ready;
    assign completing = (slot == SLOT_W'(RPW - 1)) || input_last;
    // Non-completing rows only touch the accumulator, so they never wait on the output register.
    assign input_ready = (state == S_PACK) && (!completing || reg_free);
    assign accept      = input_valid && input_ready;

    always_comb begin
        merged       = acc;
        merged[slot] = input_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_START;
            slot         <= '0;
            acc          <= '0;
            output_data  <= '0;
            output_valid <= 1'b0;
            output_last  <= 1'b0;
        end else begin
            if (reg_free)
                output_valid <= 1'b0;

            if (state == S_HDR) begin
`ifdef NUKV_PACKER_HDR_EN
                // The row stays on the input; it is consumed from S_PACK next cycle.
                if (input_valid && reg_free) begin
                    output_data  <= MEMORY_WIDTH'(value_size_data);
                    output_valid <= 1'b1;
                    output_last  <= 1'b0;
                    state        <= S_PACK;
                end
`endif
            end else if (accept) begin
                if (completing) begin
                    output_data  <= MEMORY_WIDTH'(merged);
                    output_valid <= 1'b1;
                    output_last  <= input_last;
                    acc          <= '0;
                    slot         <= '0;
`ifdef NUKV_PACKER_HDR_EN
                    if (input_last)
                        state <= S_HDR;
`endif
                end else begin
                    acc  <= merged;
                    slot <= slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nukv_row_packer.sv
// Directed bench for nukv_row_packer: queue-driven row source, beat collector, hand-built expected words.
module tb_nukv_row_packer;

`ifdef NUKV_PACKER_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  value_size_data = '0;
    logic [191:0] input_data = '0;
    logic         input_valid = 1'b0;
    logic         input_last = 1'b0;
    logic         input_ready;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_last;
    logic         output_ready = 1'b1;

    nukv_row_packer dut (
        .clk             (clk),
        .rst             (rst),
        .value_size_data (value_size_data),
        .input_data      (input_data),
        .input_valid     (input_valid),
        .input_last      (input_last),
        .input_ready     (input_ready),
        .output_data     (output_data),
        .output_valid    (output_valid),
        .output_last     (output_last),
        .output_ready    (output_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [191:0] d;
        logic         l;
        logic [15:0]  sz;
    } row_t;

    localparam logic [191:0] RA = {64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0};
    localparam logic [191:0] RB = {64'hB2B2_0000_0000_00B2, 64'hB1B1_0000_0000_00B1, 64'hB0B0_0000_0000_00B0};
    localparam logic [191:0] RC = {64'hC2C2_0000_0000_00C2, 64'hC1C1_0000_0000_00C1, 64'hC0C0_0000_0000_00C0};
    localparam logic [191:0] RD = {64'hD2D2_0000_0000_00D2, 64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0};
    localparam logic [191:0] RE = {64'hE2E2_0000_0000_00E2, 64'hE1E1_0000_0000_00E1, 64'hE0E0_0000_0000_00E0};
    localparam logic [191:0] RX = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};

    row_t         rq[$];
    logic [512:0] beats[$];
    int           bcyc[$];
    logic [512:0] expq[$];
    int           n_chk = 0;
    int           n_err = 0;
    bit           hold_chk = 1'b0;
    logic [511:0] hold_exp;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_row(input logic [191:0] d, input logic l, input logic [15:0] sz);
        row_t r;
        r.d = d; r.l = l; r.sz = sz;
        rq.push_back(r);
    endtask

    // Header word is only expected when the header feature is built in.
    task automatic exp_hdr(input logic [15:0] sz);
        if (HDR) expq.push_back({1'b0, 496'b0, sz});
    endtask

    task automatic exp_word(input logic [191:0] hi, input logic [191:0] lo, input logic l);
        expq.push_back({l, 128'b0, hi, lo});
    endtask

    // One loop iteration per cycle: drive at posedge+1, sample at negedge.
    task automatic run(input int stall_from, input int stall_len, input int drain);
        int k = 0;
        int idle = 0;
        beats.delete();
        bcyc.delete();
        while ((rq.size() > 0 || idle < drain) && k < 2000) begin
            input_valid = (rq.size() > 0);
            if (input_valid) begin
                input_data      = rq[0].d;
                input_last      = rq[0].l;
                value_size_data = rq[0].sz;
            end else begin
                input_data      = '0;
                input_last      = 1'b0;
                value_size_data = 16'hFFFF;
            end
            output_ready = !(k >= stall_from && k < stall_from + stall_len);
            @(negedge clk);
            if (hold_chk && k >= 3 && k < stall_from + stall_len) begin
                check($sformatf("hold_valid_k%0d", k), 512'(output_valid), 512'd1);
                check($sformatf("hold_data_k%0d", k), output_data, hold_exp);
                check($sformatf("hold_in_ready_k%0d", k), 512'(input_ready), 512'd0);
            end
            if (output_valid && output_ready) begin
                beats.push_back({output_last, output_data});
                bcyc.push_back(k);
            end
            if (input_valid && input_ready) void'(rq.pop_front());
            if (rq.size() == 0) idle++;
            k++;
            @(posedge clk);
            #1;
        end
        check("run_bounded", 512'(k < 2000), 512'd1);
        input_valid  = 1'b0;
        input_last   = 1'b0;
        output_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag);
        int n;
        check({tag, "_nbeats"}, 512'(beats.size()), 512'(expq.size()));
        n = (beats.size() < expq.size()) ? beats.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), beats[i][511:0], expq[i][511:0]);
            check($sformatf("%s_last%0d", tag, i), 512'(beats[i][512]), 512'(expq[i][512]));
        end
        expq.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 512'(output_valid), 512'd0);
        check("rst_last", 512'(output_last), 512'd0);
        check("rst_data", output_data, 512'd0);
        check("rst_in_ready", 512'(input_ready), 512'(!HDR));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single-row value
        push_row(RA, 1'b1, 16'h0018);
        exp_hdr(16'h0018);
        exp_word(192'b0, RA, 1'b1);
        run(1000, 0, 6);
        check_beats("t1");

        // exactly RPW rows: no empty trailing word
        push_row(RA, 1'b0, 16'h0030);
        push_row(RB, 1'b1, 16'h7777);
        exp_hdr(16'h0030);
        exp_word(RB, RA, 1'b1);
        run(1000, 0, 6);
        check_beats("t2");

        // five rows, odd tail
        push_row(RA, 1'b0, 16'h0078);
        push_row(RB, 1'b0, 16'h1111);
        push_row(RC, 1'b0, 16'h2222);
        push_row(RD, 1'b0, 16'h3333);
        push_row(RE, 1'b1, 16'h4444);
        exp_hdr(16'h0078);
        exp_word(RB, RA, 1'b0);
        exp_word(RD, RC, 1'b0);
        exp_word(192'b0, RE, 1'b1);
        run(1000, 0, 6);
        check_beats("t3");

        // backpressure with a completing row pending
        push_row(RA, 1'b0, 16'h0060);
        push_row(RB, 1'b0, 16'h0000);
        push_row(RC, 1'b0, 16'h0000);
        push_row(RD, 1'b1, 16'h0000);
        exp_hdr(16'h0060);
        exp_word(RB, RA, 1'b0);
        exp_word(RD, RC, 1'b1);
        hold_exp = HDR ? 512'h0060 : {128'b0, RB, RA};
        hold_chk = 1'b1;
        run(0, 10, 6);
        hold_chk = 1'b0;
        check_beats("t4");

        // two back-to-back 2-row values at full rate
        push_row(RA, 1'b0, 16'h0030);
        push_row(RB, 1'b1, 16'h0000);
        push_row(RC, 1'b0, 16'h0031);
        push_row(RD, 1'b1, 16'h0000);
        exp_hdr(16'h0030);
        exp_word(RB, RA, 1'b1);
        exp_hdr(16'h0031);
        exp_word(RD, RC, 1'b1);
        run(1000, 0, 6);
        check("t5_last_beat_cycle", 512'(bcyc.size() > 0 ? bcyc[bcyc.size()-1] : -1),
              512'(HDR ? 6 : 4));
        check_beats("t5");

        // reset mid-value with the header (if any) held by backpressure
        push_row(RA, 1'b0, 16'h0048);
        run(0, 1000, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid_after_rst", 512'(output_valid), 512'd0);
        @(posedge clk);
        #1;
        push_row(RX, 1'b1, 16'h0018);
        exp_hdr(16'h0018);
        exp_word(192'b0, RX, 1'b1);
        run(1000, 0, 6);
        check_beats("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
